gpo_blink_pio: RTL and testbench
================================

GPO_BLINK_PIO -- requirements
Module: gpo_blink_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 8, output port width (1..32).
REQ-002 SHALL have parameter PERIOD_W, default 24, blink half-period register width (1..32).
REQ-003 SHALL have parameter RESET_VALUE, default 0, WIDTH-bit DATA reset value.
REQ-004 SHALL have clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have address  in  3  Avalon-MM word address.
REQ-007 SHALL have chipselect  in  1  slave select.
REQ-008 SHALL have write_n  in  1  active-low write strobe.
REQ-009 SHALL have writedata  in  32  write data.
REQ-010 SHALL have readdata  out  32  read data; zero-latency, combinational from address.
REQ-011 SHALL have out_port  out  WIDTH  driven output pins.

Function
REQ-012 SHALL define write strobe = chipselect & ~write_n; a write takes effect on the next clk edge; no wait states.
REQ-013 SHALL decode: 0 DATA (rw), 1 BLINK_EN (rw), 2 PERIOD (rw), 3 STATUS (ro), 4 OUTSET (wo), 5 OUTCLEAR (wo), 6 TOGGLE (wo), 7 reserved.
REQ-014 SHALL update DATA on writes: addr0 DATA<=wd; addr4 DATA<=DATA|wd; addr5 DATA<=DATA&~wd; addr6 DATA<=DATA^wd (wd = writedata[WIDTH-1:0]).
REQ-015 SHALL load BLINK_EN<=writedata[WIDTH-1:0] on addr1 write, PERIOD<=writedata[PERIOD_W-1:0] on addr2 write.
REQ-016 SHALL return zero-extended DATA, BLINK_EN, PERIOD at addr 0/1/2; STATUS at addr3 = {30'b0, running, phase}; zero at addr 4-7.
REQ-017 SHALL run a PERIOD_W-bit counter: when PERIOD==0, counter and phase held 0, running=0; otherwise running=1, counter increments each cycle.
REQ-018 SHALL, when counter==PERIOD-1 and PERIOD!=0, wrap counter to 0 and toggle phase on the same edge (phase period = 2*PERIOD cycles).
REQ-019 SHALL, on any addr2 write, clear counter and phase on that edge, overriding wrap/toggle in the same cycle.
REQ-020 SHALL NOT disturb counter or phase on writes to BLINK_EN or DATA.
REQ-021 SHALL drive out_port = DATA & ~(BLINK_EN & {WIDTH{phase}}), registered (one cycle after DATA/BLINK_EN/phase change).
REQ-022 SHALL ignore writes to addr3 and addr7 and ignore writedata bits above WIDTH/PERIOD_W.
REQ-023 SHALL ignore reads (no side effects); readdata valid whenever address stable.

Reset
REQ-024 SHALL, while reset high, force DATA=RESET_VALUE, BLINK_EN=0, PERIOD=0, counter=0, phase=0, out_port=RESET_VALUE, asynchronously.
REQ-025 SHALL resume from reset values on the first clk edge after reset deasserts; reset mid-blink aborts the cycle with no glitch beyond immediate forcing.

Structure
REQ-026 SHALL place register address constants (ADDR_DATA..ADDR_TOGGLE) and STATUS bit indices in shared package gpo_blink_pkg.
REQ-027 SHALL implement counter/phase/running in one sub-module gpo_blink_timebase (inputs period, period_wr; outputs phase, running).

Verification
REQ-028 SHALL cover: reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, readdata addr0..3 = A5,0,0,0.
REQ-029 SHALL cover: write addr0=0x0F, addr4=0xF0, addr5=0x3C, addr6=0x81 -> DATA reads 0x0F,0xFF,0xC3,0x42.
REQ-030 SHALL cover: DATA=0xFF, BLINK_EN=0x03, PERIOD=4 -> out_port 0xFF for 4 cycles, 0xFC for 4, repeat; STATUS bit0 follows.
REQ-031 SHALL cover: PERIOD=1 -> phase toggles every cycle; then PERIOD=0 -> phase=0, running=0, out_port=DATA.
REQ-032 SHALL cover: PERIOD write landing on wrap cycle -> counter=0, phase=0 after edge (no toggle).
REQ-033 SHALL cover: reset asserted mid-blink with phase=1 -> out_port returns to RESET_VALUE immediately, all registers at reset values.

Source files
------------

// File: rtl/gpo_blink_pkg.sv
// gpo_blink_pkg: register map and STATUS bit positions shared by the blinking GPO
package gpo_blink_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] ADDR_TOGGLE   = 3'd6;

    localparam int STATUS_PHASE_BIT   = 0;
    localparam int STATUS_RUNNING_BIT = 1;

endpackage

// File: rtl/gpo_blink_timebase.sv
// gpo_blink_timebase: half-period counter producing the blink phase
module gpo_blink_timebase #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                period_wr,
    output logic                phase,
    output logic                running
);

    logic [PERIOD_W-1:0] count;
    logic                wrap;

    assign running = period != '0;
    assign wrap    = running && count == period - PERIOD_W'(1);

    // count while running; a PERIOD write restarts the cycle and beats a wrap on the same edge
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            count <= '0;
            phase <= 1'b0;
        end else if (period_wr || !running) begin
            count <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            count <= '0;
            phase <= ~phase;
        end else
            count <= count + PERIOD_W'(1);

endmodule

// File: rtl/gpo_blink_pio.sv
// gpo_blink_pio: Avalon-MM GPO with set/clear/toggle access and per-bit blinking
module gpo_blink_pio
    import gpo_blink_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               PERIOD_W    = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic                wr;
    logic [WIDTH-1:0]    wd;
    logic [WIDTH-1:0]    data;
    logic [WIDTH-1:0]    data_next;
    logic [WIDTH-1:0]    blink_en;
    logic [PERIOD_W-1:0] period;
    logic                period_wr;
    logic                phase;
    logic                running;
    logic [31:0]         status;
    logic                unused_bits;

    assign wr          = chipselect & ~write_n;
    assign wd          = writedata[WIDTH-1:0];
    assign period_wr   = wr && address == ADDR_PERIOD;
    assign unused_bits = ^writedata;

    gpo_blink_timebase #(.PERIOD_W(PERIOD_W)) u_timebase (
        .clk      (clk),
        .reset    (reset),
        .period   (period),
        .period_wr(period_wr),
        .phase    (phase),
        .running  (running)
    );

    // DATA next value for direct, set, clear and toggle writes
    always_comb
        data_next = !wr                      ? data :
                    address == ADDR_DATA     ? wd :
                    address == ADDR_OUTSET   ? data | wd :
                    address == ADDR_OUTCLEAR ? data & ~wd :
                    address == ADDR_TOGGLE   ? data ^ wd : data;

    // register file plus registered output with blinking bits blanked in phase 1
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            data     <= RESET_VALUE;
            blink_en <= '0;
            period   <= '0;
            out_port <= RESET_VALUE;
        end else begin
            data <= data_next;
            if (wr && address == ADDR_BLINK_EN)
                blink_en <= wd;
            if (period_wr)
                period <= writedata[PERIOD_W-1:0];
            out_port <= data & ~(blink_en & {WIDTH{phase}});
        end

    // STATUS word assembled from the shared bit positions
    always_comb begin
        status                     = '0;
        status[STATUS_PHASE_BIT]   = phase;
        status[STATUS_RUNNING_BIT] = running;
    end

    // zero-latency read mux; write-only and reserved addresses read as zero
    always_comb
        readdata = address == ADDR_DATA     ? 32'(data) :
                   address == ADDR_BLINK_EN ? 32'(blink_en) :
                   address == ADDR_PERIOD   ? 32'(period) :
                   address == ADDR_STATUS   ? status : '0;

endmodule

// File: tb/tb_gpo_blink_pio.sv
// tb_gpo_blink_pio: randomized and directed checks against a cycle-count reference model
module tb_gpo_blink_pio;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int checks = 0;
    int failures = 0;

    logic [7:0]  m_data, m_blink, m_out;
    int unsigned m_period;
    int unsigned m_k;

    always #5 clk = ~clk;

    gpo_blink_pio #(.WIDTH(8), .PERIOD_W(24), .RESET_VALUE(8'hA5)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    function automatic logic m_phase();
        return m_period == 0 ? 1'b0 : ((m_k / m_period) % 2) == 1;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'b0, m_data};
            3'd1:    return {24'b0, m_blink};
            3'd2:    return m_period;
            3'd3:    return {30'b0, m_period != 0, m_phase()};
            default: return 32'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_data = 8'hA5;
        m_blink = 8'h00;
        m_period = 0;
        m_k = 0;
        m_out = 8'hA5;
    endtask

    task automatic tick(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
        logic w;
        w = cs & ~wn;
        chipselect = cs;
        write_n = wn;
        address = a;
        writedata = d;
        @(posedge clk);
        m_out = m_data & ~(m_blink & {8{m_phase()}});
        if (w)
            case (a)
                3'd0: m_data = d[7:0];
                3'd1: m_blink = d[7:0];
                3'd2: m_period = {8'b0, d[23:0]};
                3'd4: m_data = m_data | d[7:0];
                3'd5: m_data = m_data & ~d[7:0];
                3'd6: m_data = m_data ^ d[7:0];
                default: ;
            endcase
        m_k = (w && a == 3'd2) ? 0 : m_k + 1;
        #1;
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_rd [4] = '{32'hA5, 32'h0, 32'h0, 32'h0};
        #1 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (out_port !== 8'hA5) begin
            failures++;
            $display("FAIL reset_out out_port=%h expected=%h", out_port, 8'hA5);
        end
        for (int a = 0; a < 4; a++) begin
            address = 3'(a);
            #1;
            checks++;
            if (readdata !== exp_rd[a]) begin
                failures++;
                $display("FAIL reset_read addr=%0d readdata=%h expected=%h", a, readdata, exp_rd[a]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        tick(1'b0, 1'b1, 3'd0, 32'h0);
        checks++;
        if (out_port !== 8'hA5) begin
            failures++;
            $display("FAIL reset_release out_port=%h expected=%h", out_port, 8'hA5);
        end
    endtask

    task automatic test_data_ops();
        logic [2:0] addrs [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
        logic [7:0] vals  [4] = '{8'h0F, 8'hF0, 8'h3C, 8'h81};
        logic [7:0] exps  [4] = '{8'h0F, 8'hFF, 8'hC3, 8'h42};
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, addrs[i], ($urandom() & 32'hFFFF_FF00) | {24'b0, vals[i]});
            address = 3'd0;
            #1;
            checks++;
            if (readdata !== {24'b0, exps[i]}) begin
                failures++;
                $display("FAIL data_op%0d readdata=%h expected=%h", i, readdata, {24'b0, exps[i]});
            end
            tick(1'b0, 1'b1, 3'd0, 32'h0);
            checks++;
            if (out_port !== exps[i]) begin
                failures++;
                $display("FAIL data_out%0d out_port=%h expected=%h", i, out_port, exps[i]);
            end
        end
        tick(1'b1, 1'b0, 3'd3, $urandom());
        tick(1'b1, 1'b0, 3'd7, $urandom());
        for (int a = 0; a < 4; a++) begin
            address = 3'(a);
            #1;
            checks++;
            if (readdata !== m_read(3'(a))) begin
                failures++;
                $display("FAIL ignored_write addr=%0d readdata=%h expected=%h", a, readdata, m_read(3'(a)));
            end
        end
    endtask

    task automatic test_blink();
        int ff_count = 0;
        int fc_count = 0;
        tick(1'b1, 1'b0, 3'd0, 32'hFF);
        tick(1'b1, 1'b0, 3'd1, 32'h03);
        tick(1'b1, 1'b0, 3'd2, 32'h4);
        for (int i = 0; i < 24; i++) begin
            if (i == 9) tick(1'b1, 1'b0, 3'd0, 32'hFF);
            else if (i == 14) tick(1'b1, 1'b0, 3'd1, 32'h03);
            else tick(1'b0, 1'b1, 3'd0, 32'h0);
            if (out_port == 8'hFF) ff_count++;
            if (out_port == 8'hFC) fc_count++;
            address = 3'd3;
            #1;
            checks++;
            if (out_port !== m_out || readdata !== m_read(3'd3)) begin
                failures++;
                $display("FAIL blink cyc=%0d out_port=%h status=%h expected out=%h status=%h",
                         i, out_port, readdata, m_out, m_read(3'd3));
            end
        end
        checks++;
        if (ff_count != 12 || fc_count != 12) begin
            failures++;
            $display("FAIL blink_duty ff=%0d fc=%0d expected 12/12", ff_count, fc_count);
        end
    endtask

    task automatic test_period1();
        logic prev;
        tick(1'b1, 1'b0, 3'd2, 32'h1);
        prev = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1, 3'd0, 32'h0);
            address = 3'd3;
            #1;
            checks++;
            if (readdata[0] !== ~prev || readdata !== m_read(3'd3)) begin
                failures++;
                $display("FAIL period1 cyc=%0d status=%h expected=%h", i, readdata, m_read(3'd3));
            end
            prev = readdata[0];
        end
        tick(1'b1, 1'b0, 3'd2, 32'h0);
        tick(1'b0, 1'b1, 3'd0, 32'h0);
        address = 3'd3;
        #1;
        checks++;
        if (readdata !== 32'h0 || out_port !== m_data) begin
            failures++;
            $display("FAIL period0 status=%h out_port=%h expected status=0 out=%h", readdata, out_port, m_data);
        end
    endtask

    task automatic test_wrap_write();
        tick(1'b1, 1'b0, 3'd2, 32'h3);
        tick(1'b0, 1'b1, 3'd0, 32'h0);
        tick(1'b0, 1'b1, 3'd0, 32'h0);
        tick(1'b1, 1'b0, 3'd2, 32'h5);
        address = 3'd3;
        #1;
        checks++;
        if (readdata !== 32'h2) begin
            failures++;
            $display("FAIL wrap_write status=%h expected=%h", readdata, 32'h2);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1, 3'd0, 32'h0);
            address = 3'd3;
            #1;
            checks++;
            if (readdata !== m_read(3'd3)) begin
                failures++;
                $display("FAIL wrap_after cyc=%0d status=%h expected=%h", i, readdata, m_read(3'd3));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_rd [4] = '{32'hA5, 32'h0, 32'h0, 32'h0};
        bit found = 0;
        tick(1'b1, 1'b0, 3'd0, 32'hFF);
        tick(1'b1, 1'b0, 3'd1, 32'hFF);
        tick(1'b1, 1'b0, 3'd2, 32'h2);
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1'b0, 1'b1, 3'd0, 32'h0);
            found = m_phase() && out_port == 8'h00;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reset_mid_setup out_port=%h expected=%h", out_port, 8'h00);
        end
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (out_port !== 8'hA5) begin
            failures++;
            $display("FAIL reset_mid_out out_port=%h expected=%h", out_port, 8'hA5);
        end
        for (int a = 0; a < 4; a++) begin
            address = 3'(a);
            #1;
            checks++;
            if (readdata !== exp_rd[a]) begin
                failures++;
                $display("FAIL reset_mid_read addr=%0d readdata=%h expected=%h", a, readdata, exp_rd[a]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        tick(1'b0, 1'b1, 3'd0, 32'h0);
        checks++;
        if (out_port !== m_out) begin
            failures++;
            $display("FAIL reset_mid_resume out_port=%h expected=%h", out_port, m_out);
        end
    endtask

    task automatic test_random();
        logic        cs, wn;
        logic [2:0]  a, ra;
        logic [31:0] d;
        for (int i = 0; i < 400; i++) begin
            cs = $urandom_range(0, 3) != 0;
            wn = $urandom_range(0, 3) == 0;
            a = 3'($urandom_range(0, 7));
            d = $urandom();
            if (a == 3'd2) d = (d & 32'hFF00_0000) | $urandom_range(0, 6);
            tick(cs, wn, a, d);
            ra = 3'($urandom_range(0, 7));
            address = ra;
            #1;
            checks++;
            if (out_port !== m_out || readdata !== m_read(ra)) begin
                failures++;
                $display("FAIL random cyc=%0d out_port=%h rd[%0d]=%h expected out=%h rd=%h",
                         i, out_port, ra, readdata, m_out, m_read(ra));
            end
        end
    endtask

    initial begin
        test_reset();
        test_data_ops();
        test_blink();
        test_period1();
        test_wrap_write();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
